// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for a multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback over a shared memory with a
// wait-state handshake (mem_ready) and a per-access timeout into a sticky
// ERROR state. Illegal opcodes and funct codes also land in ERROR.
// Optional feature: define MIPS_BNE_EN to decode bne (op 000101).
// Ports:
//   clk, reset (async, active-low)
//   op, funct, zero, mem_ready         instruction fields, ALU flag, mem handshake
//   mem_req, IorD, MemWrite, IRWrite   memory controls
//   RegDst, MemtoReg, RegWrite         register file controls
//   ALUSrcA, ALUSrcB, ALUControl       ALU controls
//   PCSrc, PCEn                        PC controls
//   state, error                       current state encoding, sticky fault
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [3:0] state,
   output logic       error
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
      S_ERROR  = 4'd15
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_BNE_EN
   localparam logic [5:0] OP_BNE  = 6'b000101;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Raw (un-gated) controls; write strobes and mem_req are gated by reset below.
   logic mem_req_c, mem_write_c, ir_write_c, reg_write_c, pc_en_c;

   // State register and wait counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath controls
   always_comb begin
      state_d     = state_q;
      mem_req_c   = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      pc_en_c     = 1'b0;
      IorD        = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUControl  = 3'b000;
      PCSrc       = 2'b00;
      unique case (state_q)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            ALUSrcB    = 2'b01;
            ALUControl = 3'b010;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_en_c    = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            ALUControl = 3'b010;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_RTEX;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
               OP_BNE:       state_d = S_BRANCH;
`endif
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = 3'b010;
            state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            IorD      = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg    = 1'b1;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_c   = 1'b1;
            IorD        = 1'b1;
            mem_write_c = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_RTEX: begin
            ALUSrcA = 1'b1;
            state_d = S_ALUWB;
            case (funct)
               6'b100000: ALUControl = 3'b010;
               6'b100010: ALUControl = 3'b110;
               6'b100100: ALUControl = 3'b000;
               6'b100101: ALUControl = 3'b001;
               6'b101010: ALUControl = 3'b111;
               default:   state_d    = S_ERROR;
            endcase
         end
         S_ALUWB: begin
            RegDst      = 1'b1;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = 3'b110;
            PCSrc      = 2'b01;
`ifdef MIPS_BNE_EN
            pc_en_c    = (op == OP_BNE) ? ~zero : zero;
`else
            pc_en_c    = zero;
`endif
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = 3'b010;
            state_d    = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCSrc   = 2'b10;
            pc_en_c = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_ERROR;
      endcase

      // Timeout only fires with mem_ready=0, so no pending strobe is ever raised.
      if (mem_req_c && !mem_ready && (cnt_q == CNT_LAST)) state_d = S_ERROR;

      if (state_d != state_q)         cnt_d = '0;
      else if (mem_req_c && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
      else                              cnt_d = cnt_q;
   end

   // Suppress all strobes while reset is held so an aborted access writes nothing.
   assign mem_req  = mem_req_c   & reset;
   assign MemWrite = mem_write_c & reset;
   assign IRWrite  = ir_write_c  & reset;
   assign RegWrite = reg_write_c & reset;
   assign PCEn     = pc_en_c     & reset;
   assign state    = state_q;
   assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl (MEM_TIMEOUT=4): per-cycle
// vectors of inputs with expected state and control outputs, plus hand
// sequences for reset, timeout and illegal-instruction corners.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic       ALUSrcA, PCEn, error;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int n_chk = 0;
   int n_err = 0;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
      .PCEn(PCEn), .state(state), .error(error)
   );

   always #5 clk = ~clk;

   // {mem_req,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
   //  ALUSrcB[1:0],ALUControl[2:0],PCSrc[1:0],PCEn,error}
   localparam logic [16:0] O_F_NR   = 17'b1_0_0_0_0_0_0_0_01_010_00_0_0;
   localparam logic [16:0] O_F_R    = 17'b1_0_0_1_0_0_0_0_01_010_00_1_0;
   localparam logic [16:0] O_DEC    = 17'b0_0_0_0_0_0_0_0_11_010_00_0_0;
   localparam logic [16:0] O_MEMADR = 17'b0_0_0_0_0_0_0_1_10_010_00_0_0;
   localparam logic [16:0] O_MEMRD  = 17'b1_1_0_0_0_0_0_0_00_000_00_0_0;
   localparam logic [16:0] O_MEMWB  = 17'b0_0_0_0_0_1_1_0_00_000_00_0_0;
   localparam logic [16:0] O_WR_NR  = 17'b1_1_0_0_0_0_0_0_00_000_00_0_0;
   localparam logic [16:0] O_WR_R   = 17'b1_1_1_0_0_0_0_0_00_000_00_0_0;
   localparam logic [16:0] O_RT_ADD = 17'b0_0_0_0_0_0_0_1_00_010_00_0_0;
   localparam logic [16:0] O_RT_SUB = 17'b0_0_0_0_0_0_0_1_00_110_00_0_0;
   localparam logic [16:0] O_RT_SLT = 17'b0_0_0_0_0_0_0_1_00_111_00_0_0;
   localparam logic [16:0] O_RT_BAD = 17'b0_0_0_0_0_0_0_1_00_000_00_0_0;
   localparam logic [16:0] O_ALUWB  = 17'b0_0_0_0_1_0_1_0_00_000_00_0_0;
   localparam logic [16:0] O_BR_T   = 17'b0_0_0_0_0_0_0_1_00_110_01_1_0;
   localparam logic [16:0] O_BR_N   = 17'b0_0_0_0_0_0_0_1_00_110_01_0_0;
   localparam logic [16:0] O_ADDIEX = 17'b0_0_0_0_0_0_0_1_10_010_00_0_0;
   localparam logic [16:0] O_ADDIWB = 17'b0_0_0_0_0_0_1_0_00_000_00_0_0;
   localparam logic [16:0] O_JUMP   = 17'b0_0_0_0_0_0_0_0_00_000_10_1_0;
   localparam logic [16:0] O_ERR    = 17'b0_0_0_0_0_0_0_0_00_000_00_0_1;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
   localparam logic [5:0] JMP = 6'b000010, BADOP = 6'b111111;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] out;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic r,
                               input logic [3:0] s, input logic [16:0] e);
      vec_t v;
      v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.st = s; v.out = e;
      return v;
   endfunction

   function automatic logic [16:0] outs();
      return {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
              ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, error};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered at posedge+1: drive inputs, check mid-cycle, then cross one edge.
   task automatic apply(input vec_t v, input string name);
      op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.rdy;
      #2;
      chk({name, " state"}, 32'(state), 32'(v.st));
      chk({name, " outs"},  32'(outs()), 32'(v.out));
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input string name);
      reset = 1'b0;
      #2;
      chk({name, " state"}, 32'(state), 32'd0);
      chk({name, " error"}, 32'(error), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      // lw: FETCH waits 2, MEMRD waits 2
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b0, 4'd0, O_F_NR));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b0, 4'd0, O_F_NR));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b1, 4'd2, O_MEMADR));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b0, 4'd3, O_MEMRD));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b0, 4'd3, O_MEMRD));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b1, 4'd3, O_MEMRD));
      tbl.push_back(mk(LW, 6'd0, 1'b0, 1'b1, 4'd4, O_MEMWB));
      // add / sub / slt
      tbl.push_back(mk(RT, F_ADD, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(RT, F_ADD, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(RT, F_ADD, 1'b0, 1'b1, 4'd6, O_RT_ADD));
      tbl.push_back(mk(RT, F_ADD, 1'b0, 1'b1, 4'd7, O_ALUWB));
      tbl.push_back(mk(RT, F_SUB, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(RT, F_SUB, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(RT, F_SUB, 1'b0, 1'b1, 4'd6, O_RT_SUB));
      tbl.push_back(mk(RT, F_SUB, 1'b0, 1'b1, 4'd7, O_ALUWB));
      tbl.push_back(mk(RT, F_SLT, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(RT, F_SLT, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(RT, F_SLT, 1'b0, 1'b1, 4'd6, O_RT_SLT));
      tbl.push_back(mk(RT, F_SLT, 1'b0, 1'b1, 4'd7, O_ALUWB));
      // beq taken then not taken
      tbl.push_back(mk(BEQ, 6'd0, 1'b1, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(BEQ, 6'd0, 1'b1, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(BEQ, 6'd0, 1'b1, 1'b1, 4'd8, O_BR_T));
      tbl.push_back(mk(BEQ, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(BEQ, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(BEQ, 6'd0, 1'b0, 1'b1, 4'd8, O_BR_N));
      // addi, j, sw without waits
      tbl.push_back(mk(ADDI, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(ADDI, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(ADDI, 6'd0, 1'b0, 1'b1, 4'd9, O_ADDIEX));
      tbl.push_back(mk(ADDI, 6'd0, 1'b0, 1'b1, 4'd10, O_ADDIWB));
      tbl.push_back(mk(JMP, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(JMP, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(JMP, 6'd0, 1'b0, 1'b1, 4'd11, O_JUMP));
      tbl.push_back(mk(SW, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R));
      tbl.push_back(mk(SW, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC));
      tbl.push_back(mk(SW, 6'd0, 1'b0, 1'b1, 4'd2, O_MEMADR));
      tbl.push_back(mk(SW, 6'd0, 1'b0, 1'b1, 4'd5, O_WR_R));
      tbl.push_back(mk(SW, 6'd0, 1'b0, 1'b0, 4'd0, O_F_NR));

      // Async reset mid-FETCH with mem_ready high: no strobes.
      op = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      reset = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst state", 32'(state), 32'd0);
      chk("rst error", 32'(error), 32'd0);
      chk("rst strobes", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Re-enter FETCH cleanly, then the vector table.
      do_reset("rst0");
      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset asserted mid-MEMRD with mem_ready high aborts at once.
      do_reset("rst1");
      apply(mk(LW, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R),    "ab fetch");
      apply(mk(LW, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC),    "ab dec");
      apply(mk(LW, 6'd0, 1'b0, 1'b1, 4'd2, O_MEMADR), "ab adr");
      mem_ready = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("abort state", 32'(state), 32'd0);
      chk("abort strobes", 32'({IRWrite, PCEn, MemWrite, RegWrite, mem_req}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // sw timeout: 4 wait cycles in MEMWR, no MemWrite, sticky ERROR.
      apply(mk(SW, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R),    "to fetch");
      apply(mk(SW, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC),    "to dec");
      apply(mk(SW, 6'd0, 1'b0, 1'b1, 4'd2, O_MEMADR), "to adr");
      for (int i = 0; i < 4; i++)
         apply(mk(SW, 6'd0, 1'b0, 1'b0, 4'd5, O_WR_NR), $sformatf("to wait%0d", i));
      apply(mk(SW, 6'd0, 1'b0, 1'b1, 4'd15, O_ERR), "to err0");
      apply(mk(SW, 6'd0, 1'b0, 1'b1, 4'd15, O_ERR), "to err1");
      apply(mk(LW, 6'd0, 1'b1, 1'b1, 4'd15, O_ERR), "to err2");

      // Illegal opcode.
      do_reset("rst2");
      apply(mk(BADOP, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R),   "bad fetch");
      apply(mk(BADOP, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC),   "bad dec");
      apply(mk(BADOP, 6'd0, 1'b0, 1'b1, 4'd15, O_ERR),  "bad err");

      // Illegal funct: no ALUWB write.
      do_reset("rst3");
      apply(mk(RT, 6'b111111, 1'b0, 1'b1, 4'd0, O_F_R),    "badf fetch");
      apply(mk(RT, 6'b111111, 1'b0, 1'b1, 4'd1, O_DEC),    "badf dec");
      apply(mk(RT, 6'b111111, 1'b0, 1'b1, 4'd6, O_RT_BAD), "badf rtex");
      apply(mk(RT, 6'b111111, 1'b0, 1'b1, 4'd15, O_ERR),   "badf err");

      // bne with zero=0.
      do_reset("rst4");
      apply(mk(BNE, 6'd0, 1'b0, 1'b1, 4'd0, O_F_R), "bne fetch");
      apply(mk(BNE, 6'd0, 1'b0, 1'b1, 4'd1, O_DEC), "bne dec");
`ifdef MIPS_BNE_EN
      apply(mk(BNE, 6'd0, 1'b0, 1'b1, 4'd8, O_BR_T), "bne branch");
`else
      apply(mk(BNE, 6'd0, 1'b0, 1'b1, 4'd15, O_ERR), "bne err");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
